// File: rtl/i2s_test_pattern_gen.sv
// I2S source emulating a 24-bit stereo ADC: ramp payload, LRCK and serial data all
// generated from the bit clock, every register changing on the falling edge of bck.
module i2s_test_pattern_gen #(
  parameter int                   WORD_BITS  = 24,
  parameter int                   SLOT_BITS  = 32,
  parameter logic [WORD_BITS-1:0] LEFT_INIT  = 24'h000000,
  parameter logic [WORD_BITS-1:0] RIGHT_INIT = 24'hFFFFFF,
  parameter int                   LEFT_STEP  = 1,
  parameter int                   RIGHT_STEP = 1
) (
  input  logic bck,
  input  logic rst_n,
  output logic lrck,
  output logic dout
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0]     SLOT_C     = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0]     LAST_C     = CNT_W'(FRAME_BITS - 1);
  localparam logic [WORD_BITS-1:0] LSTEP_C    = WORD_BITS'(LEFT_STEP);
  localparam logic [WORD_BITS-1:0] RSTEP_C    = WORD_BITS'(RIGHT_STEP);

  if (WORD_BITS > SLOT_BITS - 1) begin : g_bad_params
    $error("WORD_BITS must not exceed SLOT_BITS-1");
  end

  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [WORD_BITS-1:0] left_reg, left_next;
  logic [WORD_BITS-1:0] right_reg, right_next;
  logic                 lrck_reg, lrck_next;
  logic                 dout_reg, dout_next;

  logic                 slot_next;
  logic [CNT_W-1:0]     pos_next;
  logic [WORD_BITS-1:0] word_sel;
  logic [WORD_BITS:1]   bit_hit;

  // Outputs are derived from the counter value being loaded on this edge.
  always_comb begin
    cnt_next  = (cnt_reg == LAST_C) ? '0 : cnt_reg + 1'b1;
    slot_next = (cnt_next >= SLOT_C);
    pos_next  = slot_next ? cnt_next - SLOT_C : cnt_next;
    word_sel  = slot_next ? right_reg : left_reg;
  end

  // Position p (1..WORD_BITS) carries bit WORD_BITS-p, giving the one-bit I2S delay.
  for (genvar gi = 1; gi <= WORD_BITS; gi++) begin : g_bit_sel
    assign bit_hit[gi] = (pos_next == CNT_W'(gi)) && word_sel[WORD_BITS-gi];
  end

  always_comb begin
    lrck_next  = slot_next;
    dout_next  = |bit_hit;
    left_next  = left_reg;
    right_next = right_reg;
    // Payload advances on the wrap edge, where dout is forced low by pos 0.
    if (cnt_reg == LAST_C) begin
      left_next  = left_reg + LSTEP_C;
      right_next = right_reg - RSTEP_C;
    end
  end

  always_ff @(negedge bck) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      lrck_reg  <= 1'b0;
      dout_reg  <= 1'b0;
      left_reg  <= LEFT_INIT;
      right_reg <= RIGHT_INIT;
    end else begin
      cnt_reg   <= cnt_next;
      lrck_reg  <= lrck_next;
      dout_reg  <= dout_next;
      left_reg  <= left_next;
      right_reg <= right_next;
    end
  end

  assign lrck = lrck_reg;
  assign dout = dout_reg;

endmodule

// File: tb/tb_i2s_test_pattern_gen.sv
// Bench for i2s_test_pattern_gen: three parameterisations run side by side against an
// edge-count model of the frame layout, with directed and random reset pulses.
module tb_i2s_test_pattern_gen;

  localparam int NI = 3;

  logic          bck   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] lrck_w;
  logic [NI-1:0] dout_w;

  i2s_test_pattern_gen u_def (
    .bck  (bck),
    .rst_n(rst_n),
    .lrck (lrck_w[0]),
    .dout (dout_w[0])
  );

  i2s_test_pattern_gen #(
    .LEFT_INIT (24'hFFFFFF),
    .RIGHT_INIT(24'h000000)
  ) u_wrap (
    .bck  (bck),
    .rst_n(rst_n),
    .lrck (lrck_w[1]),
    .dout (dout_w[1])
  );

  i2s_test_pattern_gen #(
    .LEFT_INIT (24'hA5A5A5),
    .RIGHT_INIT(24'h3C1234),
    .LEFT_STEP (7),
    .RIGHT_STEP(300)
  ) u_alt (
    .bck  (bck),
    .rst_n(rst_n),
    .lrck (lrck_w[2]),
    .dout (dout_w[2])
  );

  always #5 bck = ~bck;

  logic [23:0] li [NI] = '{24'h000000, 24'hFFFFFF, 24'hA5A5A5};
  logic [23:0] ri [NI] = '{24'hFFFFFF, 24'h000000, 24'h3C1234};
  int          ls [NI] = '{1, 1, 7};
  int          rs [NI] = '{1, 1, 300};

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          n            = 0;   // non-reset falling edges since the last reset edge
  bit          valid        = 1'b0;
  logic [23:0] shreg [NI];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame k carries INIT +/- k*STEP, modulo 2^24.
  function automatic logic [23:0] exp_word(input int i, input int k, input int slot);
    logic [31:0] tmp;
    if (slot == 0) tmp = 32'(li[i]) + 32'(k * ls[i]);
    else           tmp = 32'(ri[i]) - 32'(k * rs[i]);
    return tmp[23:0];
  endfunction

  // One bck period: compare outputs at the rising edge, then choose rst_n for the next falling edge.
  task automatic step(input bit rst);
    int          t, k, slot, pos;
    logic [23:0] w;
    logic        eb;
    @(posedge bck);
    if (valid) begin
      t    = n % 64;
      k    = n / 64;
      slot = t / 32;
      pos  = t % 32;
      for (int i = 0; i < NI; i++) begin
        w  = exp_word(i, k, slot);
        eb = (pos >= 1 && pos <= 24) ? w[24-pos] : 1'b0;
        check_val($sformatf("lrck%0d_n%0d", i, n), 32'(lrck_w[i]), 32'(slot));
        check_val($sformatf("dout%0d_n%0d", i, n), 32'(dout_w[i]), 32'(eb));
        if (pos >= 1 && pos <= 24) shreg[i] = {shreg[i][22:0], dout_w[i]};
        if (pos == 24) begin
          $display("[TB] inst%0d frame %0d %s word=%06h expected=%06h",
                   i, k, (slot == 0) ? "L" : "R", shreg[i], w);
          check_val($sformatf("word%0d_k%0d_s%0d", i, k, slot), 32'(shreg[i]), 32'(w));
        end
      end
    end
    rst_n = !rst;
    if (rst) begin
      n     = 0;
      valid = 1'b1;
    end else if (valid) begin
      n++;
    end
  endtask

  initial begin
    repeat (4) step(1'b1);
    repeat (4 * 64 + 8) step(1'b0);
    while ((n % 64) != 40) step(1'b0);
    step(1'b1);
    repeat (3 * 64) step(1'b0);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        repeat ($urandom_range(1, 4)) step(1'b1);
      end else begin
        step(1'b0);
      end
    end
    step(1'b0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
